pwm_fade: RTL
=============

Name: pwm_fade

Overview:
- Duty-cycle sequencer that drives the 16-bit duty input of the binary-weighted PWM stage.
- Accepts fade commands (target, step, hold) over a valid/ready handshake.
- Ramps its duty output toward the target by one step per PWM period, then holds for a programmable number of periods.
- Duty changes only at PWM period boundaries, so the PWM stage never sees a mid-period change.

Parameters:
- PERIOD_BITS, 16, log2 of the PWM period in clocks. Must equal the PWM stage counter width; benches use 4.
- HOLD_BITS, 8, width of the hold-period count.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_target  in  16  final duty value
- cmd_step  in  16  duty change per period; 0 = jump to target at next tick
- cmd_hold  in  HOLD_BITS  periods to hold at target before done
- abort  in  1  cancel active command
- duty  out  16  duty word to the PWM stage
- frame_tick  out  1  one-cycle pulse on the last clock of each PWM period
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when a command completes normally

Behaviour:
- Reset values: frame_cnt=0, duty=0, state=IDLE, cmd_ready=1, busy=0, done=0, frame_tick=0, hold_cnt=0.
- frame_cnt is a PERIOD_BITS-bit free-running counter that wraps.
  - frame_tick is combinational: high when frame_cnt == 2**PERIOD_BITS-1.
  - First tick after reset occurs at clock 2**PERIOD_BITS-1; then every 2**PERIOD_BITS clocks.
  - The PWM stage counter shares the same reset, so duty updates land on its count 0.
- duty is registered and updates only on clocks where frame_tick=1. The new value is visible the following clock.
- Handshake:
  - A command is accepted when cmd_valid & cmd_ready.
  - On acceptance, target, step and hold are latched and state becomes RAMP on the next clock.
  - Inputs are ignored while cmd_ready=0.
  - Acceptance may occur on a tick clock; duty does not change on that tick.
- States:
  - IDLE: cmd_ready=1, duty frozen.
  - RAMP: on each frame_tick:
    - diff = |target - duty|, computed at 17 bits with no wrap.
    - If step==0 or diff <= step: duty <= target and arrive.
    - Else duty <= duty + step when target > duty, or duty - step otherwise.
    - No overflow or underflow is possible, so no saturation logic is needed.
    - Arrive: if hold==0, go to IDLE and pulse done. Otherwise hold_cnt <= hold and go to HOLD.
  - HOLD: on each frame_tick:
    - Decrement hold_cnt.
    - When the decrement reaches 0, go to IDLE and pulse done.
    - Total hold = hold periods after arrival.
- done is registered: high for exactly the clock after the completing tick, coincident with state=IDLE and cmd_ready=1.
- target == current duty in RAMP: arrives at the first tick; duty is unchanged.
- abort:
  - In RAMP or HOLD: state becomes IDLE next clock, duty frozen at its current value, no done.
  - abort on a tick clock takes priority over the duty update.
  - In IDLE: no effect; a simultaneous cmd_valid is still accepted.
- reset mid-command: all state returns to reset values next clock, including duty=0 and frame_cnt=0.

Test Plan:
- PERIOD_BITS=4, reset released, idle 40 clocks -> frame_tick high at clocks 15 and 31 only; duty=0; cmd_ready=1; done never.
- Command target=1000, step=300, hold=0 -> duty goes 300, 600, 900, 1000 on successive ticks; done pulses once the clock after the 4th tick; busy low thereafter.
- From duty=1000, command target=100, step=0, hold=2 -> duty=100 after the first tick; done the clock after the 3rd tick; cmd_ready low throughout.
- Command target=0xFFFF, step=0xFFFF from duty=0x8000 -> duty=0xFFFF at the first tick with no wrap. Then target=0, step=0xFFFF -> duty=0 with no underflow.
- abort asserted on a tick clock during a ramp 0->5000 step 1000 at duty=2000 -> duty stays 2000, no done, cmd_ready=1 next clock. A cmd_valid held during RAMP is not accepted until IDLE.
- reset asserted mid-HOLD at duty=700 -> next clock: duty=0, busy=0, frame_cnt=0; next tick 15 clocks later.

Source files
------------

// File: rtl/pwm_fade_if.sv
// Fade command channel: target, step and hold offered on a valid/ready handshake.
// Latency: none (bundle of wires only).
// Backpressure: the sequencer holds cmd_ready low while a command is in progress.
interface pwm_fade_if #(
    parameter int HOLD_BITS = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [15:0]          cmd_target;
    logic [15:0]          cmd_step;
    logic [HOLD_BITS-1:0] cmd_hold;

    // Command source drives the payload and valid.
    modport master (
        output cmd_valid,
        output cmd_target,
        output cmd_step,
        output cmd_hold,
        input  cmd_ready
    );

    // The sequencer consumes commands and drives ready.
    modport slave (
        input  cmd_valid,
        input  cmd_target,
        input  cmd_step,
        input  cmd_hold,
        output cmd_ready
    );
endinterface

// File: rtl/pwm_fade.sv
// Duty sequencer: ramps the PWM duty word toward a target one step per period, then holds.
// Latency: duty changes on the clock after a frame_tick; done is the clock after the final tick.
// Backpressure: cmd_ready is high only in IDLE; commands offered while busy wait.
module pwm_fade #(
    parameter int PERIOD_BITS = 16,
    parameter int HOLD_BITS   = 8
) (
    input  logic        clock,
    input  logic        reset,
    pwm_fade_if.slave   cmd,
    input  logic        abort,
    output logic [15:0] duty,
    output logic        frame_tick,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RAMP = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                 state_q,     state_d;
    logic [PERIOD_BITS-1:0] frame_cnt_q, frame_cnt_d;
    logic [15:0]            duty_q,      duty_d;
    logic [15:0]            tgt_q,       tgt_d;
    logic [15:0]            step_q,      step_d;
    logic [HOLD_BITS-1:0]   hold_q,      hold_d;
    logic [HOLD_BITS-1:0]   hold_cnt_q,  hold_cnt_d;
    logic                   done_q,      done_d;

    logic                   ramp_up;
    logic [16:0]            diff;
    logic                   arrive;

    // Distance to target is taken at 17 bits so a full-scale swing never wraps.
    assign ramp_up = tgt_q > duty_q;
    assign diff    = ramp_up ? ({1'b0, tgt_q} - {1'b0, duty_q})
                             : ({1'b0, duty_q} - {1'b0, tgt_q});
    assign arrive  = (step_q == 16'd0) || (diff <= {1'b0, step_q});

    assign frame_tick    = (frame_cnt_q == '1);
    assign cmd.cmd_ready = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign duty          = duty_q;
    assign done          = done_q;

    // Next-state logic: duty only moves on a tick, abort wins over any tick-time update.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q + PERIOD_BITS'(1);
        duty_d      = duty_q;
        tgt_d       = tgt_q;
        step_d      = step_q;
        hold_d      = hold_q;
        hold_cnt_d  = hold_cnt_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    tgt_d   = cmd.cmd_target;
                    step_d  = cmd.cmd_step;
                    hold_d  = cmd.cmd_hold;
                    state_d = S_RAMP;
                end
            end
            S_RAMP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (frame_tick) begin
                    if (arrive) begin
                        duty_d = tgt_q;
                        if (hold_q == '0) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            hold_cnt_d = hold_q;
                            state_d    = S_HOLD;
                        end
                    end else if (ramp_up) begin
                        duty_d = duty_q + step_q;
                    end else begin
                        duty_d = duty_q - step_q;
                    end
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (frame_tick) begin
                    hold_cnt_d = hold_cnt_q - HOLD_BITS'(1);
                    if (hold_cnt_q == HOLD_BITS'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset also realigns the period counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            frame_cnt_q <= '0;
            duty_q      <= '0;
            tgt_q       <= '0;
            step_q      <= '0;
            hold_q      <= '0;
            hold_cnt_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            duty_q      <= duty_d;
            tgt_q       <= tgt_d;
            step_q      <= step_d;
            hold_q      <= hold_d;
            hold_cnt_q  <= hold_cnt_d;
            done_q      <= done_d;
        end
    end

endmodule
